axi_lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank, the successor to the fixed 4-register control slave in the ADC capture path (ad9643 DDR_RESET / DATA_EN control).
- Provides C_NUM_RW control registers and C_NUM_RO status registers.
- Accepts the AW and W channels independently, returns SLVERR for illegal accesses, and emits per-register write pulses.
- Sits between the PS AXI interconnect and the ADC interface/capture logic.

---
 rtl/axi_lite_regbank_pkg.sv | 41 ++++
 rtl/axi_lite_skid1.sv | 36 +++
 rtl/axi_lite_regbank.sv | 195 +++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_regbank_pkg.sv
// Shared constants and address decode helpers for the AXI4-Lite register bank.
// Used by the top level and by the bench to name response codes.
package axi_lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_RW,
        REG_RO,
        REG_UNMAPPED
    } region_e;

    typedef struct packed {
        region_e    region;
        logic [5:0] idx;
    } decode_t;

    // Byte-address bits that sit below the word index.
    function automatic int unsigned addr_lsb(input int unsigned dw);
        return (dw == 64) ? 3 : 2;
    endfunction

    // Map a word index onto the RW block, the RO block or nothing.
    function automatic decode_t decode(input logic [31:0] word,
                                       input int unsigned nrw,
                                       input int unsigned nro);
        decode_t d;
        d.region = REG_UNMAPPED;
        d.idx    = '0;
        if (word < 32'(nrw)) begin
            d.region = REG_RW;
            d.idx    = word[5:0];
        end else if (word < 32'(nrw + nro)) begin
            d.region = REG_RO;
            d.idx    = 6'(word - 32'(nrw));
        end
        return d;
    endfunction

endpackage

// File: rtl/axi_lite_skid1.sv
// One-entry valid/ready holding register.
// Accepts only when empty; drains when the consumer pops it.
module axi_lite_skid1 #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         pop_i
);

    logic         full_q;
    logic [W-1:0] data_q;

    assign ready_o = !full_q;
    assign valid_o = full_q;
    assign data_o  = data_q;

    // Capture a beat when empty, release it when the consumer pops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (full_q && pop_i) begin
            full_q <= 1'b0;
        end else if (valid_i && !full_q) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave with RW control and RO status registers.
// Independent AW/W holding, per-register write pulses, SLVERR on bad access.
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_RW           = 8,
    parameter int C_NUM_RO           = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RW_RESET = '0,
    localparam int DW   = C_S_AXI_DATA_WIDTH,
    localparam int AW   = C_S_AXI_ADDR_WIDTH,
    localparam int SW   = DW / 8,
    localparam int NRO1 = (C_NUM_RO > 0) ? C_NUM_RO : 1
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    input  logic [AW-1:0]          S_AXI_AWADDR,
    input  logic [2:0]             S_AXI_AWPROT,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [DW-1:0]          S_AXI_WDATA,
    input  logic [SW-1:0]          S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [AW-1:0]          S_AXI_ARADDR,
    input  logic [2:0]             S_AXI_ARPROT,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [DW-1:0]          S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [C_NUM_RW*DW-1:0] CTRL_REGS,
    output logic [C_NUM_RW-1:0]    CTRL_WR_PULSE,
    input  logic [NRO1*DW-1:0]     STATUS_REGS
);

    localparam int ADDR_LSB = addr_lsb(DW);

    logic [DW-1:0]       regs_q  [C_NUM_RW];
    logic [DW-1:0]       regs_d  [C_NUM_RW];
    logic [C_NUM_RW-1:0] pulse_q, pulse_d;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic                rvalid_q;
    logic [1:0]          rresp_q, rresp_d;
    logic [DW-1:0]       rdata_q, rdata_d;

    logic                aw_full, w_full, wr_commit, ar_hs;
    logic [AW-1:0]       aw_addr, aw_word, ar_word;
    logic [DW+SW-1:0]    w_beat;
    logic [DW-1:0]       w_data;
    logic [SW-1:0]       w_strb;
    decode_t             aw_dec, ar_dec;

    axi_lite_skid1 #(.W(AW)) u_aw (
        .clk_i   (S_AXI_ACLK),
        .rst_i   (S_AXI_ARESET),
        .valid_i (S_AXI_AWVALID),
        .data_i  (S_AXI_AWADDR),
        .ready_o (S_AXI_AWREADY),
        .valid_o (aw_full),
        .data_o  (aw_addr),
        .pop_i   (wr_commit)
    );

    axi_lite_skid1 #(.W(DW + SW)) u_w (
        .clk_i   (S_AXI_ACLK),
        .rst_i   (S_AXI_ARESET),
        .valid_i (S_AXI_WVALID),
        .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .ready_o (S_AXI_WREADY),
        .valid_o (w_full),
        .data_o  (w_beat),
        .pop_i   (wr_commit)
    );

    assign w_data    = w_beat[DW-1:0];
    assign w_strb    = w_beat[DW+SW-1:DW];
    assign wr_commit = aw_full && w_full && !bvalid_q;
    assign aw_word   = aw_addr >> ADDR_LSB;
    assign ar_word   = S_AXI_ARADDR >> ADDR_LSB;
    assign aw_dec    = decode(32'(aw_word), C_NUM_RW, C_NUM_RO);
    assign ar_dec    = decode(32'(ar_word), C_NUM_RW, C_NUM_RO);
    assign ar_hs     = S_AXI_ARVALID && !rvalid_q;

    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign CTRL_WR_PULSE = pulse_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Flatten the register array onto the control bus.
    always_comb begin
        CTRL_REGS = '0;
        for (int i = 0; i < C_NUM_RW; i++) begin
            CTRL_REGS[i*DW +: DW] = regs_q[i];
        end
    end

    // Strobe-gated update and pulse for the addressed RW register.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < C_NUM_RW; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_commit && aw_dec.region == REG_RW) begin
            for (int i = 0; i < C_NUM_RW; i++) begin
                if (int'(aw_dec.idx) == i) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < SW; b++) begin
                        if (w_strb[b]) begin
                            regs_d[i][b*8 +: 8] = w_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Register array, pulses and write response.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < C_NUM_RW; i++) begin
                regs_q[i] <= C_RW_RESET;
            end
            pulse_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            for (int i = 0; i < C_NUM_RW; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pulse_q <= pulse_d;
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (aw_dec.region == REG_RW) ? RESP_OKAY
                                                      : RESP_SLVERR;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read mux over pre-write register values and live status inputs.
    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        case (ar_dec.region)
            REG_RW: begin
                rresp_d = RESP_OKAY;
                for (int i = 0; i < C_NUM_RW; i++) begin
                    if (int'(ar_dec.idx) == i) rdata_d = regs_q[i];
                end
            end
            REG_RO: begin
                rresp_d = RESP_OKAY;
                for (int i = 0; i < NRO1; i++) begin
                    if (int'(ar_dec.idx) == i) begin
                        rdata_d = STATUS_REGS[i*DW +: DW];
                    end
                end
            end
            default: begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        endcase
    end

    // Read response register, held until the master takes it.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank with queued expected responses.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_axi_lite_regbank;
    import axi_lite_regbank_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int NRW = 8;
    localparam int NRO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NRW*DW-1:0] ctrl;
    logic [NRW-1:0]    pulse;
    logic [NRO*DW-1:0] status;

    int errors = 0;
    int checks = 0;
    int b_cnt = 0;
    int p_cnt = 0;
    logic [1:0]    b_q[$];
    logic [33:0]   r_q[$];

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_NUM_RW           (NRW),
        .C_NUM_RO           (NRO),
        .C_RW_RESET         ('0)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .CTRL_REGS     (ctrl),
        .CTRL_WR_PULSE (pulse),
        .STATUS_REGS   (status)
    );

    always @(posedge clk) begin
        if (bvalid && bready) b_cnt <= b_cnt + 1;
        if (|pulse) p_cnt <= p_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] creg(input int i);
        return ctrl[i*DW +: DW];
    endfunction

    task automatic do_aw(input logic [AW-1:0] a);
        int n = 0;
        awaddr  = a;
        awvalid = 1'b1;
        while (!awready && n < 30) begin
            tick();
            n++;
        end
        if (!awready) check("aw_timeout", {63'd0, awready}, 64'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [DW-1:0] d, input logic [3:0] s);
        int n = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!wready && n < 30) begin
            tick();
            n++;
        end
        if (!wready) check("w_timeout", {63'd0, wready}, 64'd1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag);
        int n = 0;
        logic [1:0] exp;
        bready = 1'b1;
        while (!bvalid && n < 30) begin
            tick();
            n++;
        end
        exp = b_q.pop_front();
        check({tag, "_bvalid"}, {63'd0, bvalid}, 64'd1);
        check({tag, "_bresp"}, {62'd0, bresp}, {62'd0, exp});
        tick();
        bready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] s,
                            input logic [1:0] resp);
        b_q.push_back(resp);
        do_aw(a);
        do_w(d, s);
        wait_b(tag);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] resp);
        int n = 0;
        logic [33:0] exp;
        r_q.push_back({resp, d});
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 30) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        exp = r_q.pop_front();
        check({tag, "_rvalid"}, {63'd0, rvalid}, 64'd1);
        check({tag, "_arready"}, {63'd0, arready}, 64'd0);
        check({tag, "_rdata"}, {32'd0, rdata}, {32'd0, exp[31:0]});
        check({tag, "_rresp"}, {62'd0, rresp}, {62'd0, exp[33:32]});
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, "_rvalid_clr"}, {63'd0, rvalid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, bc;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        status = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset state and reset-value readback
        check("rst_awready", {63'd0, awready}, 64'd1);
        check("rst_wready", {63'd0, wready}, 64'd1);
        check("rst_arready", {63'd0, arready}, 64'd1);
        check("rst_bvalid", {63'd0, bvalid}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_pulse", {56'd0, pulse}, 64'd0);
        check("rst_ctrl3", {32'd0, creg(3)}, 64'd0);
        do_read("rd_idx3", 6'h0C, 32'h0, RESP_OKAY);

        // 2: W three cycles ahead of AW
        b_q.push_back(RESP_OKAY);
        do_w(32'hDEADBEEF, 4'hF);
        check("w_held_wready", {63'd0, wready}, 64'd0);
        tick(); tick(); tick();
        check("w_held_ctrl2", {32'd0, creg(2)}, 64'd0);
        do_aw(6'h08);
        check("pre_commit_pulse", {56'd0, pulse}, 64'd0);
        tick();
        check("commit_pulse", {56'd0, pulse}, 64'h04);
        check("commit_ctrl2", {32'd0, creg(2)}, 64'hDEADBEEF);
        check("commit_bvalid", {63'd0, bvalid}, 64'd1);
        check("commit_awready", {63'd0, awready}, 64'd1);
        check("commit_wready", {63'd0, wready}, 64'd1);
        tick();
        check("pulse_one_cycle", {56'd0, pulse}, 64'd0);
        wait_b("wr_idx2");

        // 3: byte strobes
        do_write("wr_idx0_full", 6'h00, 32'hFFFFFFFF, 4'hF, RESP_OKAY);
        do_write("wr_idx0_strb", 6'h00, 32'h11223344, 4'b0101, RESP_OKAY);
        do_read("rd_idx0", 6'h00, 32'hFF22FF44, RESP_OKAY);
        do_write("wr_idx0_nostrb", 6'h01, 32'h0, 4'b0000, RESP_OKAY);
        do_read("rd_idx0_nostrb", 6'h03, 32'hFF22FF44, RESP_OKAY);

        // 4: RO write rejected, RO read, unmapped read
        status[1*DW +: DW] = 32'h0000A5A5;
        pc = p_cnt;
        do_write("wr_idx9", 6'h24, 32'h12345678, 4'hF, RESP_SLVERR);
        check("ro_no_pulse", 64'(p_cnt), 64'(pc));
        check("ro_ctrl1", {32'd0, creg(1)}, 64'd0);
        do_read("rd_idx9", 6'h24, 32'h0000A5A5, RESP_OKAY);
        do_read("rd_idx12", 6'h30, 32'h0, RESP_SLVERR);

        // 5: back-pressured B with a second write queued behind it
        b_q.push_back(RESP_OKAY);
        do_aw(6'h10);
        do_w(32'hAAAA0001, 4'hF);
        do_aw(6'h14);
        do_w(32'h00005555, 4'hF);
        check("bp_awready", {63'd0, awready}, 64'd0);
        check("bp_wready", {63'd0, wready}, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        check("bp_bvalid", {63'd0, bvalid}, 64'd1);
        check("bp_ctrl4", {32'd0, creg(4)}, 64'hAAAA0001);
        check("bp_ctrl5", {32'd0, creg(5)}, 64'd0);
        wait_b("bp_first");
        b_q.push_back(RESP_OKAY);
        wait_b("bp_second");
        check("bp2_ctrl5", {32'd0, creg(5)}, 64'h00005555);

        // 6: reset between AW and W drops the transaction
        do_aw(6'h0C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_awready", {63'd0, awready}, 64'd1);
        check("mid_rst_bvalid", {63'd0, bvalid}, 64'd0);
        pc = p_cnt;
        bc = b_cnt;
        do_write("wr_idx1", 6'h04, 32'h12345678, 4'hF, RESP_OKAY);
        tick();
        tick();
        check("fresh_ctrl1", {32'd0, creg(1)}, 64'h12345678);
        check("stale_ctrl3", {32'd0, creg(3)}, 64'd0);
        check("fresh_one_b", 64'(b_cnt - bc), 64'd1);
        check("fresh_one_pulse", 64'(p_cnt - pc), 64'd1);
        check("fresh_no_bvalid", {63'd0, bvalid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
